instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  RV32I fetch stage. Upstream of decode/alu: owns the architectural PC and issues word reads to
//  instruction memory. Buffers returned words with their PCs in an in-order queue and hands them
//  to decode over a valid/ready handshake. Accepts redirects (alu pc_next_address on a taken
//  branch/jump) and flushes wrong-path state.
// PARAMETERS
//  DATA_WIDTH    32            instruction/PC width
//  FIFO_DEPTH    4             queue entries; power of 2, >=2
//  RESET_VECTOR  32'h0000_0000 first fetch PC after reset
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           async reset, active-high
//  imem_req_valid  out  1           fetch request valid
//  imem_req_ready  in   1           memory accepts request
//  imem_req_addr   out  DATA_WIDTH  word address of request (bits[1:0]=0)
//  imem_rsp_valid  in   1           response valid; in order, >=1 cycle after accept
//  imem_rsp_data   in   DATA_WIDTH  instruction word
//  instr_valid     out  1           queue head valid to decode
//  instr_ready     in   1           decode consumes head
//  instr_data      out  DATA_WIDTH  head instruction
//  instr_pc        out  DATA_WIDTH  head PC (drives alu pc_current_address)
//  redirect_valid  in   1           flush + restart fetch
//  redirect_pc     in   DATA_WIDTH  restart PC
//  fetch_fault     out  1           sticky misaligned-redirect flag (only with FETCH_ALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset: imem_req_valid=0, imem_req_addr=RESET_VECTOR, instr_valid=0, instr_data=0,
//   instr_pc=0, fetch_fault=0, fetch_pc=RESET_VECTOR, queue empty, outstanding=0, drop=0, state=IDLE.
//   Reset mid-transaction discards everything; late responses after reset are ignored because drop=0
//   and outstanding=0 (the bench must not return them).
//  FSM: IDLE -> RUN (first cycle after reset deassert). RUN -> RUN.
//   HALT entered only via the align check; exit only by reset.
//  Request: imem_req_valid=1 in RUN when outstanding+count < FIFO_DEPTH and no redirect this cycle.
//   On accept (valid&ready), fetch_pc += 4 and outstanding++. Addr/valid are stable until accepted.
//  Response: if drop>0, discard and decrement drop. Otherwise push {data, pc}, where pc is taken
//   from an internal in-order PC tag queue, and decrement outstanding.
//  Handshake: head pops when instr_valid&instr_ready. Push and pop in the same cycle keep count unchanged.
//   Full-queue push cannot occur by the credit rule; assert on violation. Empty: instr_valid=0.
//  Redirect (highest priority): same cycle, the queue and PC tags are cleared and any pop is ignored.
//   drop <= outstanding minus any response consumed this cycle. outstanding <= 0.
//   fetch_pc <= {redirect_pc[31:2],2'b00}. A request presented that cycle is withdrawn (valid=0).
//   Fetch resumes next cycle, so the first new-path request comes 1 cycle after redirect.
//   Redirect while drop>0 accumulates drop.
//  Widths: fetch_pc wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC -> 0). Counters are clog2(FIFO_DEPTH)+1 bits.
//  Latency: redirect-to-instr_valid = 1 + memory latency + 1 (registered queue output).
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//   - redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky), flushes as normal, enters HALT.
//   - In HALT there are no new requests; the queue drains to decode.
//  FETCH_ALIGN_CHECK_EN undefined:
//   - bits[1:0] are silently cleared and fetch_fault is tied 0.
// STRUCTURE
//  rv32i_pkg: fetch_state_t enum {IDLE,RUN,HALT}; ILEN=4 PC increment constant; NOP=32'h0000_0013.
//  Sub-module fetch_fifo (DEPTH, WIDTH=2*DATA_WIDTH, push/pop/flush, count, async rst),
//   instantiated once for {instr, pc}. The PC tag queue reuses fetch_fifo with WIDTH=DATA_WIDTH.
// TESTING
//  1. Reset, ready=1, 1-cycle mem -> requests 0x0,0x4,0x8,0xC. instr_pc sequence is 0,4,8,C
//     with the matching data.
//  2. instr_ready=0 -> at most 4 accepts, then imem_req_valid=0. Raising ready resumes in order
//     with no loss or duplicate.
//  3. 3-cycle mem, 2 in flight, redirect_pc=0x100 -> both late responses are dropped.
//     The next request addr is 0x100 and the first instr_pc is 0x100.
//  4. Redirect in the same cycle as pop and response arrival -> no wrong-path instr_valid after.
//     drop is correct, and the 0x200 path proceeds.
//  5. fetch_pc=0xFFFF_FFFC -> next request addr is 0x0000_0000.
//  6. FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_fault=1, no further requests.
//     Without the macro: the fetch addr is 0x100 and fetch_fault=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: fetch FSM states, PC increment and the canonical NOP encoding.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned ILEN = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue with synchronous flush; used for the {instr, pc} queue and the PC tag queue.
// The head is read straight from the storage registers and reads as zero when the queue is empty.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (!full || do_pop);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Callers size their requests so a push never meets a full queue without a pop.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads, queues {instr, pc} for decode, handles redirects.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect sets sticky fetch_fault and halts fetching.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic [DATA_WIDTH-1:0]   tag_pc;
    logic [DATA_WIDTH-1:0]   redirect_base;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           drop;
    logic [CW-1:0]           q_count;
    logic [CW:0]             in_use;
    logic [2*DATA_WIDTH-1:0] q_head;
    logic                    credit_ok;
    logic                    req_fire;
    logic                    rsp_drop;
    logic                    rsp_take;
    logic                    q_pop;
    logic                    redirect_misaligned;
    logic                    q_full_unused;
    logic                    tag_valid_unused;
    logic                    tag_full_unused;
    logic [CW-1:0]           tag_count_unused;

    // Handshakes are valid/ready: a transfer happens on a rising edge where both are high;
    // a valid request holds its address until accepted, except that a redirect withdraws it.
    assign in_use        = {1'b0, outstanding} + {1'b0, q_count};
    assign credit_ok     = in_use < (CW+1)'(FIFO_DEPTH);
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_drop      = imem_rsp_valid && (drop != '0);
    assign rsp_take      = imem_rsp_valid && (drop == '0) && (outstanding != '0);
    assign q_pop         = instr_valid && instr_ready;
    assign redirect_base = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign imem_req_addr = fetch_pc;
    assign instr_data    = q_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign instr_pc      = q_head[DATA_WIDTH-1:0];

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault         = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_misaligned) begin
            fault_q <= 1'b1;
        end
    end
`else
    logic redirect_low_unused;

    assign redirect_low_unused = ^redirect_pc[1:0];
    assign redirect_misaligned = 1'b0;
    assign fetch_fault         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     imem_req_valid = credit_ok && !redirect_valid;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (redirect_misaligned) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight (minus a response landing now) belongs to the old path.
            fetch_pc    <= redirect_base;
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(rsp_drop || rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + DATA_WIDTH'(ILEN);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DATA_WIDTH)
    ) u_instr_q (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (rsp_take),
        .push_data  ({imem_rsp_data, tag_pc}),
        .pop        (q_pop),
        .head_data  (q_head),
        .head_valid (instr_valid),
        .count      (q_count),
        .full       (q_full_unused)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_pc_tag_q (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (req_fire),
        .push_data  (fetch_pc),
        .pop        (rsp_take),
        .head_data  (tag_pc),
        .head_valid (tag_valid_unused),
        .count      (tag_count_unused),
        .full       (tag_full_unused)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: fixed-latency memory model, expected-queue scoreboard, directed scenarios.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ecnt = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          acc_save;
    logic [63:0] exp_q[$];
    mreq_t       mq[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (4),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge counter; edge k consumes whatever was presented in the cycle before it.
    always @(posedge clk) ecnt <= ecnt + 1;

    // Memory: record accepts, answer in order 'lat' cycles later. Contents: 0xABC0_0013 + addr.
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            mq.push_back('{due: ecnt + 1 + lat, addr: imem_req_addr});
            acc_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst || mq.size() == 0 || mq[0].due != ecnt + 1) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hABC0_0013 + mq[0].addr;
            void'(mq.pop_front());
        end
    end

    // Monitor: every accepted instruction must match the next expected {pc, data}.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_instr: got pc %h data %h expected none", instr_pc, instr_data);
            end else begin
                chk("instr", {instr_pc, instr_data}, exp_q.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
        exp_q.push_back({pc, data});
    endtask

    // Leaves rst released at edge0+2; the next rising edge is edge 1 (IDLE -> RUN).
    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        mq.delete();
        exp_q.delete();
        acc_cnt = 0;
        rst     = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d left expected 0 left", name, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    task automatic redirect_at(input int edge_k, input logic [31:0] pc);
        repeat (edge_k) @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(imem_req_addr), 64'h0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_data", 64'(instr_data), 64'h0);
        chk("rst_instr_pc", 64'(instr_pc), 64'h0);
        chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);

        // 1: straight-line fetch, 1-cycle memory
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h0000_0000, 32'hABC0_0013);
        push_exp(32'h0000_0004, 32'hABC0_0017);
        push_exp(32'h0000_0008, 32'hABC0_001B);
        push_exp(32'h0000_000C, 32'hABC0_001F);
        @(posedge clk);
        @(negedge clk);
        chk("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_first_req_addr", 64'(imem_req_addr), 64'h0);
        wait_drain("t1");

        // 2: decode stalled -> credit stops at 4, then resume in order
        lat = 1;
        do_reset();
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t2_accepts", 64'(acc_cnt), 64'd4);
        chk("t2_req_valid_stalled", 64'(imem_req_valid), 64'd0);
        chk("t2_instr_valid", 64'(instr_valid), 64'd1);
        chk("t2_head_pc", 64'(instr_pc), 64'h0);
        push_exp(32'h0000_0000, 32'hABC0_0013);
        push_exp(32'h0000_0004, 32'hABC0_0017);
        push_exp(32'h0000_0008, 32'hABC0_001B);
        push_exp(32'h0000_000C, 32'hABC0_001F);
        push_exp(32'h0000_0010, 32'hABC0_0023);
        push_exp(32'h0000_0014, 32'hABC0_0027);
        push_exp(32'h0000_0018, 32'hABC0_002B);
        push_exp(32'h0000_001C, 32'hABC0_002F);
        @(posedge clk);
        #2;
        instr_ready = 1'b1;
        wait_drain("t2");

        // 3: 3-cycle memory, two in flight, redirect to 0x100 drops both
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h0000_0100, 32'hABC0_0113);
        push_exp(32'h0000_0104, 32'hABC0_0117);
        push_exp(32'h0000_0108, 32'hABC0_011B);
        repeat (3) @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        chk("t3_in_flight", 64'(acc_cnt), 64'd2);
        chk("t3_req_withdrawn", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_new_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t3_new_req_addr", 64'(imem_req_addr), 64'h100);
        wait_drain("t3");

        // 4: redirect coinciding with a pop and a response arrival
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h0000_0000, 32'hABC0_0013);
        push_exp(32'h0000_0004, 32'hABC0_0017);
        push_exp(32'h0000_0200, 32'hABC0_0213);
        push_exp(32'h0000_0204, 32'hABC0_0217);
        push_exp(32'h0000_0208, 32'hABC0_021B);
        repeat (5) @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        chk("t4_pop_pending", 64'(instr_valid), 64'd1);
        chk("t4_rsp_arriving", 64'(imem_rsp_valid), 64'd1);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        wait_drain("t4");

        // 5: PC wraps from 0xFFFF_FFFC to 0
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'hFFFF_FFFC, 32'hABC0_000F);
        push_exp(32'h0000_0000, 32'hABC0_0013);
        push_exp(32'h0000_0004, 32'hABC0_0017);
        redirect_at(1, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
        wait_drain("t5");

        // 6: misaligned redirect to 0x102
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_at(1, 32'h0000_0102);
        @(negedge clk);
        chk("t6_fault_set", 64'(fetch_fault), 64'd1);
        acc_save = acc_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_no_requests", 64'(acc_cnt), 64'(acc_save));
        chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_fault_sticky", 64'(fetch_fault), 64'd1);
        instr_ready = 1'b0;
`else
        push_exp(32'h0000_0100, 32'hABC0_0113);
        push_exp(32'h0000_0104, 32'hABC0_0117);
        redirect_at(1, 32'h0000_0102);
        @(negedge clk);
        chk("t6_req_addr", 64'(imem_req_addr), 64'h100);
        chk("t6_fault_clear", 64'(fetch_fault), 64'd0);
        wait_drain("t6");
        acc_save = acc_cnt;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
